// File: rtl/mc_alu.sv
// Multi-cycle ALU for the Mini SRC datapath: single-cycle logic/arith/shift ops,
// radix-2 Booth signed multiply and restoring signed divide behind a start/done handshake.
module mc_alu #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [OP_W-1:0]      op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 zero,
    output logic                 div_zero,
    output logic                 illegal
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int CNT_W   = SHAMT_W + 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MUL_RUN = 2'd1;
    localparam logic [1:0] DIV_RUN = 2'd2;
    localparam logic [1:0] DIV_FIX = 2'd3;

    localparam logic [OP_W-1:0] OP_OR   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SHR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SHRA = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SHL  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_ROR  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_ROL  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_NEG  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_NOT  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(11);
    localparam logic [OP_W-1:0] OP_DIV  = OP_W'(12);

    logic [1:0]         state;
    logic [CNT_W-1:0]   counter;
    // acc/lo/aux are shared: Booth {hi, multiplier, multiplicand} or divide {rem, quot, divisor}
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH:0]     aux;
    logic               q_bit;
    logic               q_neg;
    logic               r_neg;

    logic [SHAMT_W-1:0] shamt;
    logic [2*WIDTH-1:0] dbl_r;
    logic [2*WIDTH-1:0] dbl_l;
    logic [WIDTH-1:0]   alu_r;
    logic               alu_ok;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;

    logic [WIDTH:0]     booth_sum;
    logic [WIDTH:0]     booth_acc;
    logic [WIDTH-1:0]   booth_lo;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH:0]     div_acc;
    logic [WIDTH-1:0]   div_lo;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign busy = (state != IDLE);

    always_comb begin
        shamt  = b[SHAMT_W-1:0];
        dbl_r  = {a, a} >> shamt;
        dbl_l  = {a, a} << shamt;
        a_abs  = a[WIDTH-1] ? -a : a;
        b_abs  = b[WIDTH-1] ? -b : b;
        alu_r  = '0;
        alu_ok = 1'b1;
        case (op)
            OP_OR:   alu_r = a | b;
            OP_ADD:  alu_r = a + b;
            OP_AND:  alu_r = a & b;
            OP_SUB:  alu_r = a - b;
            OP_SHR:  alu_r = a >> shamt;
            OP_SHRA: alu_r = $unsigned($signed(a) >>> shamt);
            OP_SHL:  alu_r = a << shamt;
            OP_ROR:  alu_r = dbl_r[WIDTH-1:0];
            OP_ROL:  alu_r = dbl_l[2*WIDTH-1:WIDTH];
            OP_NEG:  alu_r = -b;
            OP_NOT:  alu_r = ~b;
            OP_MUL,
            OP_DIV:  alu_r = '0;
            default: alu_ok = 1'b0;
        endcase
    end

    // The extra hi bit keeps MIN*MIN exact through the add/sub before the shift
    always_comb begin
        case ({lo[0], q_bit})
            2'b01:   booth_sum = acc + aux;
            2'b10:   booth_sum = acc - aux;
            default: booth_sum = acc;
        endcase
        booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        booth_lo  = {booth_sum[0], lo[WIDTH-1:1]};
    end

    always_comb begin
        div_sh   = {acc[WIDTH-1:0], lo[WIDTH-1]};
        div_diff = div_sh - aux;
        if (!div_diff[WIDTH]) begin
            div_acc = div_diff;
            div_lo  = {lo[WIDTH-2:0], 1'b1};
        end else begin
            div_acc = div_sh;
            div_lo  = {lo[WIDTH-2:0], 1'b0};
        end
        quot_fix = q_neg ? -lo : lo;
        rem_fix  = r_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            counter  <= '0;
            acc      <= '0;
            lo       <= '0;
            aux      <= '0;
            q_bit    <= 1'b0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            div_zero <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        div_zero <= 1'b0;
                        illegal  <= 1'b0;
                        if (op == OP_MUL) begin
                            state   <= MUL_RUN;
                            counter <= CNT_W'(WIDTH);
                            acc     <= '0;
                            lo      <= b;
                            aux     <= {a[WIDTH-1], a};
                            q_bit   <= 1'b0;
                        end else if (op == OP_DIV && b != '0) begin
                            state   <= DIV_RUN;
                            counter <= CNT_W'(WIDTH);
                            acc     <= '0;
                            lo      <= a_abs;
                            aux     <= {1'b0, b_abs};
                            q_neg   <= a[WIDTH-1] ^ b[WIDTH-1];
                            r_neg   <= a[WIDTH-1];
                        end else if (op == OP_DIV) begin
                            result   <= {a, {WIDTH{1'b1}}};
                            zero     <= 1'b0;
                            div_zero <= 1'b1;
                            done     <= 1'b1;
                        end else begin
                            result  <= {{WIDTH{1'b0}}, alu_r};
                            zero    <= (alu_r == '0);
                            illegal <= !alu_ok;
                            done    <= 1'b1;
                        end
                    end
                end
                MUL_RUN: begin
                    acc     <= booth_acc;
                    lo      <= booth_lo;
                    q_bit   <= lo[0];
                    counter <= counter - CNT_W'(1);
                    if (counter == CNT_W'(1)) begin
                        state  <= IDLE;
                        result <= {booth_acc[WIDTH-1:0], booth_lo};
                        zero   <= ({booth_acc[WIDTH-1:0], booth_lo} == '0);
                        done   <= 1'b1;
                    end
                end
                DIV_RUN: begin
                    acc     <= div_acc;
                    lo      <= div_lo;
                    counter <= counter - CNT_W'(1);
                    if (counter == CNT_W'(1))
                        state <= DIV_FIX;
                end
                DIV_FIX: begin
                    state  <= IDLE;
                    result <= {rem_fix, quot_fix};
                    zero   <= ({rem_fix, quot_fix} == '0);
                    done   <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_alu.sv
// Scoreboard bench for mc_alu (WIDTH=32): expectations are queued at issue
// and checked by a monitor when done pulses.
module tb_mc_alu;

    logic        clock;
    logic        reset;
    logic        start;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        zero;
    logic        div_zero;
    logic        illegal;

    mc_alu #(.WIDTH(32), .OP_W(5)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .zero(zero),
        .div_zero(div_zero), .illegal(illegal)
    );

    typedef struct {
        int unsigned id;
        logic [63:0] res;
        logic        dz;
        logic        ill;
        int          lat;
        int          bsy;
        int          cyc0;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          busy_cnt = 0;
    int unsigned next_id = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic [31:0] r;
        logic [4:0]  sh;
        longint      n, d, q, rm;
        sh    = y[4:0];
        r     = '0;
        e.id  = 0;
        e.res = '0;
        e.dz  = 1'b0;
        e.ill = 1'b0;
        e.lat = 1;
        e.bsy = 0;
        e.cyc0 = 0;
        case (o)
            5'd0:  r = x | y;
            5'd1:  r = x + y;
            5'd2:  r = x & y;
            5'd3:  r = x - y;
            5'd4:  r = x >> sh;
            5'd5:  r = $signed(x) >>> sh;
            5'd6:  r = x << sh;
            5'd7:  r = (x >> sh) | (x << (32 - sh));
            5'd8:  r = (x << sh) | (x >> (32 - sh));
            5'd9:  r = 32'd0 - y;
            5'd10: r = ~y;
            default: ;
        endcase
        if (o <= 5'd10) begin
            e.res = {32'd0, r};
        end else if (o == 5'd11) begin
            n = longint'($signed(x));
            d = longint'($signed(y));
            e.res = n * d;
            e.lat = 33;
            e.bsy = 32;
        end else if (o == 5'd12) begin
            if (y == 32'd0) begin
                e.res = {x, 32'hFFFF_FFFF};
                e.dz  = 1'b1;
            end else begin
                n  = longint'($signed(x));
                d  = longint'($signed(y));
                q  = n / d;
                rm = n % d;
                e.res = {rm[31:0], q[31:0]};
                e.lat = 34;
                e.bsy = 33;
            end
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    // Drives one start pulse; push=0 for starts that must be ignored or discarded
    task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, input bit push);
        exp_t e;
        if (push) begin
            e      = model(o, x, y);
            e.id   = next_id++;
            e.cyc0 = cyc;
            sb.push_back(e);
        end
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clock);
        #1;
        start = 1'b0;
        op    = 5'($urandom_range(0, 12));
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit && sb.size() != 0; i++) begin
            @(negedge clock);
            #1;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic run(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        issue(o, x, y, 1'b1);
        wait_drain(100);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (done) begin
                    chk("done_while_busy", 64'(busy), 64'd0);
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("result#%0d", e.id), result, e.res);
                        chk($sformatf("zero#%0d", e.id), 64'(zero), 64'(e.res == 64'd0));
                        chk($sformatf("div_zero#%0d", e.id), 64'(div_zero), 64'(e.dz));
                        chk($sformatf("illegal#%0d", e.id), 64'(illegal), 64'(e.ill));
                        chk($sformatf("latency#%0d", e.id), 64'(cyc - e.cyc0), 64'(e.lat));
                        chk($sformatf("busy_cycles#%0d", e.id), 64'(busy_cnt), 64'(e.bsy));
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    initial begin : stim
        bit got_done;
        reset = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clock);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        chk("rst_div_zero", 64'(div_zero), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        run(5'd0, 32'h1, 32'h10);
        run(5'd2, 32'hFFFF, 32'hF000);
        run(5'd1, 32'hFFFF_FFFF, 32'h2);
        run(5'd3, 32'd3, 32'd5);
        run(5'd3, 32'h1234, 32'h1234);
        run(5'd4, 32'h8000_0000, 32'd4);
        run(5'd5, 32'h8000_0000, 32'd4);
        run(5'd6, 32'h0000_00F1, 32'h25);
        run(5'd7, 32'h1234_5678, 32'd4);
        run(5'd8, 32'h1234_5678, 32'd8);
        run(5'd7, 32'hDEAD_BEEF, 32'd0);
        run(5'd9, 32'd5, 32'd5);
        run(5'd10, 32'h0, 32'h0F0F_0F0F);

        run(5'd11, 32'hFFFF_FFFD, 32'd7);
        run(5'd11, 32'h8000_0000, 32'h8000_0000);
        run(5'd11, 32'h7FFF_FFFF, 32'h8000_0000);
        run(5'd11, 32'd0, 32'h1234_5678);
        run(5'd12, 32'hFFFF_FFF9, 32'd2);
        run(5'd12, 32'h8000_0000, 32'hFFFF_FFFF);
        run(5'd12, 32'd100, 32'hFFFF_FFF9);
        run(5'd12, 32'd3, 32'd10);
        for (int i = 0; i < 8; i++)
            run(5'($urandom_range(0, 12)), $urandom, $urandom | 32'h1);

        run(5'd12, 32'd5, 32'd0);
        run(5'd1, 32'd2, 32'd3);

        // Start while busy is ignored; a start in the done cycle is accepted
        issue(5'd11, 32'h0001_2345, 32'hFFFF_FF00, 1'b1);
        repeat (9) @(posedge clock);
        #1;
        issue(5'd1, 32'd40, 32'd2, 1'b0);
        got_done = 1'b0;
        for (int i = 0; i < 60 && !got_done; i++) begin
            @(negedge clock);
            got_done = done;
        end
        chk("mul_done_seen", 64'(got_done), 64'd1);
        issue(5'd1, 32'd7, 32'd8, 1'b1);
        wait_drain(100);

        // Reset mid-multiply discards the operation
        issue(5'd11, 32'd123, 32'd456, 1'b0);
        repeat (14) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_result", result, 64'd0);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        #1;
        run(5'd11, 32'hFFFF_FFF6, 32'hFFFF_FFF6);
        run(5'd1, 32'd10, 32'd20);

        run(5'd20, 32'd1, 32'd2);
        run(5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(5'd0, 32'd0, 32'd0);

        repeat (5) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
